// File: rtl/fcvtint_resstage.sv
// Result stage for float-to-integer conversion: range check, RISC-V saturation,
// NV/NX flag generation, and a registered valid/ready output with a one-entry skid.
module fcvtint_resstage #(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            Flush,
  input  logic            InValid,
  output logic            InReady,
  input  logic            Signed,
  input  logic            Int64,
  input  logic            Xs,
  input  logic            NaNIn,
  input  logic            InexactIn,
  input  logic [1:0]      CvtNegResMsbs,
  input  logic [XLEN+1:0] CvtNegRes,
  output logic            OutValid,
  input  logic            OutReady,
  output logic [XLEN-1:0] IntRes,
  output logic            FlgNV,
  output logic            FlgNX
);

  typedef struct packed {
    logic [XLEN-1:0] res;
    logic            nv;
    logic            nx;
  } entry_t;

  // Bit 0 = main entry valid, bit 1 = skid entry valid; both are direct register bits.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b11
  } state_t;

  state_t state_q, state_d;
  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  entry_t in_entry;

  logic        int64_eff;
  logic        low_nz;
  logic        ovf;
  logic        nv;
  logic [63:0] raw;
  logic [63:0] ext;
  logic        accept;
  logic        pop;

  // The two guard MSBs only matter through CvtNegResMsbs.
  logic unused_top;
  assign unused_top = &{1'b0, CvtNegRes[XLEN+1:XLEN]};

  // Range check, saturation and flag formation on the incoming item.
  always_comb begin
    int64_eff = (XLEN == 64) ? Int64 : 1'b0;
    low_nz    = int64_eff ? (|CvtNegRes[XLEN-1:0]) : (|CvtNegRes[31:0]);
    ovf       = Signed ? (CvtNegResMsbs[1] ^ CvtNegResMsbs[0])
                       : ((|CvtNegResMsbs) | (Xs & low_nz));
    nv        = NaNIn | ovf;
    raw       = 64'(CvtNegRes[XLEN-1:0]);
    if (nv) begin
      if (NaNIn | ~Xs) begin
        raw = Signed ? (int64_eff ? 64'h7FFF_FFFF_FFFF_FFFF : 64'h0000_0000_7FFF_FFFF)
                     : 64'hFFFF_FFFF_FFFF_FFFF;
      end else begin
        raw = Signed ? (int64_eff ? 64'h8000_0000_0000_0000 : 64'h0000_0000_8000_0000)
                     : 64'h0;
      end
    end
    // 32-bit results are always sign-extended, unsigned ones included.
    ext          = int64_eff ? raw : {{32{raw[31]}}, raw[31:0]};
    in_entry.res = ext[XLEN-1:0];
    in_entry.nv  = nv;
    in_entry.nx  = InexactIn & ~nv;
  end

  assign OutValid = state_q[0];
  assign InReady  = ~state_q[1];
  assign accept   = InValid & ~state_q[1];
  assign pop      = state_q[0] & OutReady;

  assign IntRes = main_q.res;
  assign FlgNV  = main_q.nv;
  assign FlgNX  = main_q.nx;

  // Skid-buffer next-state: flush wins over accept and pop.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (Flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            main_d  = in_entry;
            state_d = ONE;
          end
        end
        ONE: begin
          if (accept && pop) begin
            main_d = in_entry;
          end else if (accept) begin
            skid_d  = in_entry;
            state_d = FULL;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            main_d  = skid_q;
            state_d = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // State and entry registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

endmodule

// File: tb/tb_fcvtint_resstage.sv
// Scoreboard bench for fcvtint_resstage: driver pushes expected results on accept,
// monitor pops and compares whenever the DUT hands a result downstream.
module tb_fcvtint_resstage;
  localparam int unsigned XLEN = 64;

  typedef struct packed {
    logic        sgn;
    logic        i64;
    logic        xs;
    logic        nan;
    logic        inex;
    logic [1:0]  msbs;
    logic [65:0] res;
  } item_t;

  typedef struct packed {
    logic [63:0] res;
    logic        nv;
    logic        nx;
  } exp_t;

  logic            clk = 1'b0;
  logic            reset;
  logic            Flush;
  logic            InValid;
  logic            InReady;
  logic            Signed;
  logic            Int64;
  logic            Xs;
  logic            NaNIn;
  logic            InexactIn;
  logic [1:0]      CvtNegResMsbs;
  logic [XLEN+1:0] CvtNegRes;
  logic            OutValid;
  logic            OutReady;
  logic [XLEN-1:0] IntRes;
  logic            FlgNV;
  logic            FlgNX;

  int   total = 0;
  int   bad = 0;
  int   pop_cnt = 0;
  exp_t sb[$];

  fcvtint_resstage #(.XLEN(XLEN)) dut (
    .clk(clk), .reset(reset), .Flush(Flush), .InValid(InValid), .InReady(InReady),
    .Signed(Signed), .Int64(Int64), .Xs(Xs), .NaNIn(NaNIn), .InexactIn(InexactIn),
    .CvtNegResMsbs(CvtNegResMsbs), .CvtNegRes(CvtNegRes), .OutValid(OutValid),
    .OutReady(OutReady), .IntRes(IntRes), .FlgNV(FlgNV), .FlgNX(FlgNX)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [65:0] act, input logic [65:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h, wanted %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: result as the integer the rules describe, in plain 64-bit arithmetic.
  function automatic exp_t model(input item_t it);
    exp_t        e;
    int          w;
    logic [63:0] lo;
    logic [63:0] r;
    bit          ovf;
    w  = it.i64 ? 64 : 32;
    lo = (w == 64) ? it.res[63:0] : {32'd0, it.res[31:0]};
    if (it.sgn) ovf = (it.msbs == 2'b01) || (it.msbs == 2'b10);
    else        ovf = (it.msbs != 2'b00) || (it.xs && lo != 64'd0);
    e.nv = it.nan || ovf;
    e.nx = it.inex && !e.nv;
    if (!e.nv)                  r = lo;
    else if (it.nan || !it.xs)  r = it.sgn ? (64'd1 << (w - 1)) - 64'd1
                                           : ((w == 64) ? ~64'd0 : 64'hFFFF_FFFF);
    else                        r = it.sgn ? 64'd0 - (64'd1 << (w - 1)) : 64'd0;
    if (w == 32) r = {{32{r[31]}}, r[31:0]};
    e.res = r;
    return e;
  endfunction

  function automatic item_t mk(input logic sgn, input logic i64, input logic xs, input logic nan,
                               input logic inex, input logic [1:0] msbs, input logic [65:0] res);
    item_t it;
    it.sgn = sgn; it.i64 = i64; it.xs = xs; it.nan = nan;
    it.inex = inex; it.msbs = msbs; it.res = res;
    return it;
  endfunction

  function automatic exp_t mke(input logic [63:0] r, input logic nv, input logic nx);
    exp_t e;
    e.res = r; e.nv = nv; e.nx = nx;
    return e;
  endfunction

  // One cycle of stimulus, entered and left at posedge+1.
  task automatic drive(input item_t it, input bit v, input bit fl, input bit rdy,
                       input bit use_exp, input exp_t ex, output bit acc);
    InValid = v; Flush = fl; OutReady = rdy;
    Signed = it.sgn; Int64 = it.i64; Xs = it.xs; NaNIn = it.nan;
    InexactIn = it.inex; CvtNegResMsbs = it.msbs; CvtNegRes = it.res;
    @(negedge clk);
    acc = v && InReady && !fl;
    @(posedge clk);
    if (fl) sb.delete();
    if (acc) sb.push_back(use_exp ? ex : model(it));
    #1;
  endtask

  task automatic idle(input bit rdy);
    bit a;
    drive('0, 1'b0, 1'b0, rdy, 1'b0, '0, a);
  endtask

  function automatic item_t rand_item();
    item_t it;
    it.sgn  = 1'($urandom);
    it.i64  = 1'($urandom);
    it.xs   = 1'($urandom);
    it.nan  = ($urandom_range(0, 9) == 0);
    it.inex = 1'($urandom);
    it.msbs = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom);
    case ($urandom_range(0, 3))
      0:       it.res = 66'd0;
      1:       it.res = 66'($urandom_range(0, 15));
      default: it.res = 66'({$urandom, $urandom, $urandom});
    endcase
    return it;
  endfunction

  // Monitor: occupancy, stall stability, and in-order result checks.
  logic [65:0] held;
  bit          hold_v = 1'b0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        hold_v = 1'b0;
      end else begin
        chk("out_valid", 66'(OutValid), 66'(sb.size() != 0));
        chk("in_ready", 66'(InReady), 66'(sb.size() < 2));
        if (hold_v && OutValid) chk("stall_hold", {IntRes, FlgNV, FlgNX}, held);
        if (OutValid && OutReady && !Flush) begin
          if (sb.size() == 0) begin
            total++; bad++;
            $display("FAIL pop_empty: got result %h, wanted no result", IntRes);
          end else begin
            e = sb.pop_front();
            chk("int_res", 66'(IntRes), 66'(e.res));
            chk("flg_nv", 66'(FlgNV), 66'(e.nv));
            chk("flg_nx", 66'(FlgNX), 66'(e.nx));
            pop_cnt++;
          end
        end
        hold_v = OutValid && !OutReady && !Flush;
        held   = {IntRes, FlgNV, FlgNX};
      end
    end
  end

  initial begin
    item_t dir_it[10];
    exp_t  dir_ex[10];
    item_t st[4];
    bit    acc;
    int    idx;
    int    p0;

    reset = 1'b1; Flush = 1'b0; InValid = 1'b0; OutReady = 1'b0;
    Signed = 1'b0; Int64 = 1'b0; Xs = 1'b0; NaNIn = 1'b0; InexactIn = 1'b0;
    CvtNegResMsbs = 2'b00; CvtNegRes = '0;
    #1;
    chk("rst_out_valid", 66'(OutValid), 66'd0);
    chk("rst_int_res", 66'(IntRes), 66'd0);
    chk("rst_nv_nx", 66'({FlgNV, FlgNX}), 66'd0);
    chk("rst_in_ready", 66'(InReady), 66'd1);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;

    // Directed corner cases with hand-derived results.
    dir_it[0] = mk(1, 0, 0, 0, 1, 2'b00, 66'd5);                  dir_ex[0] = mke(64'h5, 0, 1);
    dir_it[1] = mk(1, 0, 0, 0, 1, 2'b01, 66'h1_8000_0000);        dir_ex[1] = mke(64'h0000_0000_7FFF_FFFF, 1, 0);
    dir_it[2] = mk(1, 0, 1, 0, 0, 2'b10, 66'h2_7FFF_FFFF);        dir_ex[2] = mke(64'hFFFF_FFFF_8000_0000, 1, 0);
    dir_it[3] = mk(0, 1, 1, 0, 0, 2'b00, 66'h0_FFFF_FFFF_FFFF_FFFB); dir_ex[3] = mke(64'h0, 1, 0);
    dir_it[4] = mk(0, 1, 1, 0, 1, 2'b00, 66'd0);                  dir_ex[4] = mke(64'h0, 0, 1);
    dir_it[5] = mk(0, 0, 1, 1, 1, 2'b00, 66'd7);                  dir_ex[5] = mke(64'hFFFF_FFFF_FFFF_FFFF, 1, 0);
    dir_it[6] = mk(0, 0, 0, 0, 0, 2'b00, 66'hFFFF_FFFF);          dir_ex[6] = mke(64'hFFFF_FFFF_FFFF_FFFF, 0, 0);
    dir_it[7] = mk(1, 1, 0, 0, 1, 2'b01, 66'd3);                  dir_ex[7] = mke(64'h7FFF_FFFF_FFFF_FFFF, 1, 0);
    dir_it[8] = mk(0, 1, 0, 0, 0, 2'b01, 66'd3);                  dir_ex[8] = mke(64'hFFFF_FFFF_FFFF_FFFF, 1, 0);
    dir_it[9] = mk(1, 1, 1, 0, 0, 2'b10, 66'd3);                  dir_ex[9] = mke(64'h8000_0000_0000_0000, 1, 0);
    for (int i = 0; i < 10; i++) begin
      drive(dir_it[i], 1'b1, 1'b0, 1'b1, 1'b1, dir_ex[i], acc);
      chk("dir_accept", 66'(acc), 66'd1);
    end
    idle(1'b1); idle(1'b1);

    // Four-item stream with a two-cycle downstream stall in the middle.
    for (int i = 0; i < 4; i++) st[i] = mk(1, 1, 0, 0, 0, 2'b00, 66'(100 + i));
    p0 = pop_cnt;
    idx = 0;
    for (int c = 0; c < 16; c++) begin
      drive(st[idx < 4 ? idx : 0], idx < 4, 1'b0, !(c == 2 || c == 3),
            1'b1, mke(64'(100 + idx), 0, 0), acc);
      if (acc) idx++;
    end
    chk("stream_sent", 66'(idx), 66'd4);
    chk("stream_pops", 66'(pop_cnt - p0), 66'd4);

    // Flush while full, with a new item offered in the same cycle.
    drive(rand_item(), 1'b1, 1'b0, 1'b0, 1'b0, '0, acc);
    drive(rand_item(), 1'b1, 1'b0, 1'b0, 1'b0, '0, acc);
    chk("full_before_flush", 66'(InReady), 66'd0);
    drive(rand_item(), 1'b1, 1'b1, 1'b0, 1'b0, '0, acc);
    chk("flush_out_valid", 66'(OutValid), 66'd0);
    chk("flush_in_ready", 66'(InReady), 66'd1);
    idle(1'b1);

    // Asynchronous reset with an item held in the output register.
    drive(mk(1, 1, 0, 0, 1, 2'b00, 66'd42), 1'b1, 1'b0, 1'b0, 1'b0, '0, acc);
    drive(mk(1, 1, 0, 0, 1, 2'b00, 66'd43), 1'b1, 1'b0, 1'b0, 1'b0, '0, acc);
    #1 reset = 1'b1;
    #1;
    chk("arst_out_valid", 66'(OutValid), 66'd0);
    chk("arst_int_res", 66'(IntRes), 66'd0);
    chk("arst_nv_nx", 66'({FlgNV, FlgNX}), 66'd0);
    chk("arst_in_ready", 66'(InReady), 66'd1);
    sb.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    idle(1'b1); idle(1'b1);

    // Randomized traffic with random backpressure and occasional flushes.
    for (int c = 0; c < 400; c++) begin
      drive(rand_item(), $urandom_range(0, 9) < 7, $urandom_range(0, 49) == 0,
            $urandom_range(0, 9) < 7, 1'b0, '0, acc);
    end
    for (int c = 0; c < 4; c++) idle(1'b1);
    chk("drained", 66'(sb.size()), 66'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
